paj_cmd_seq: RTL and testbench
==============================

PAJ_CMD_SEQ -- requirements
Module: paj_cmd_seq

Interface
REQ-001 Parameters (name, default, meaning): CLK_HZ, 50_000_000, sys_clk frequency; WAKE_US, 1000, settle time after wake-up; POLL_MS, 100, gesture poll interval; MAX_RETRY, 3, NACK retries per command.
REQ-002 sys_clk  in  1  system clock.
REQ-003 sys_rstn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse; begins (or restarts) the bring-up sequence.
REQ-005 cmd_valid  out  1  command request to the byte-level I2C master.
REQ-006 cmd_ready  in  1  master accepts the command in a cycle where cmd_valid=1.
REQ-007 cmd_rd  out  1  1 = register read, 0 = register write.
REQ-008 cmd_dev  out  7  slave address, constant 7'h73.
REQ-009 cmd_reg, cmd_wdata  out  8 each  register address and write data.
REQ-010 rsp_valid  in  1  one-cycle pulse marking command completion.
REQ-011 rsp_nack  in  1  qualified by rsp_valid; 1 = slave did not acknowledge.
REQ-012 rsp_data  in  8  read data, qualified by rsp_valid.
REQ-013 gesture_valid  out  1  one-cycle pulse; gesture holds a new nonzero code.
REQ-014 gesture  out  8  last nonzero value read from register 0x43.
REQ-015 busy, init_done, err  out  1 each  sequence running, bring-up complete, sequence aborted.

Function
REQ-016 The block SHALL derive a 1 us tick from CLK_HZ/1_000_000 sys_clk cycles; all waits count ticks.
REQ-017 The FSM states SHALL be IDLE, WAKE, WAKE_WAIT, CHK_ID, INIT, BANK0, POLL_WAIT, POLL_RD, ERR.
REQ-018 IDLE -> WAKE on start; every other state -> WAKE on start (restart), discarding any outstanding response.
REQ-019 WAKE: issue write reg 0xEF data 0x00; any response, NACK included, -> WAKE_WAIT.
REQ-020 WAKE_WAIT: wait WAKE_US ticks, then -> CHK_ID.
REQ-021 CHK_ID: read reg 0x00; rsp_data==0x20 -> INIT; any other value -> ERR.
REQ-022 INIT: write entries 0..INIT_LEN-1 of the init table in order, one command per entry; after the last ACK -> BANK0.
REQ-023 BANK0: write reg 0xEF data 0x00; on ACK set init_done=1 -> POLL_WAIT.
REQ-024 POLL_WAIT: wait POLL_MS*1000 ticks -> POLL_RD; POLL_RD: read reg 0x43 -> POLL_WAIT.
REQ-025 If the POLL_RD value is nonzero, gesture SHALL load it and gesture_valid SHALL pulse for exactly the cycle after rsp_valid; a zero value produces no pulse and leaves gesture unchanged.
REQ-026 cmd_valid SHALL rise only when no command is outstanding; cmd_rd, cmd_reg and cmd_wdata SHALL stay stable until the cmd_valid&&cmd_ready cycle; cmd_valid SHALL drop the following cycle.
REQ-027 A command is outstanding from acceptance until rsp_valid; rsp_valid outside this window SHALL be ignored.
REQ-028 A NACK (outside WAKE) SHALL reissue the same command; after MAX_RETRY consecutive NACKs on one command -> ERR. The retry count clears on each ACK.
REQ-029 ERR: err=1, busy=0, init_done=0; no commands issued; exit only on start.
REQ-030 busy SHALL be 1 in all states except IDLE, POLL_WAIT and ERR.
REQ-031 Simultaneous start and rsp_valid: start wins and the response is dropped.

Reset
REQ-032 On sys_rstn low: state IDLE; cmd_valid, gesture_valid, busy, init_done and err = 0; gesture, cmd_reg and cmd_wdata = 0x00; cmd_rd = 0; all counters = 0. Reset takes effect immediately, including mid-command.

Structure
REQ-033 Package paj_pkg SHALL hold PAJ_ADDR=7'h73, REG_BANK=8'hEF, REG_ID=8'h00, ID_VAL=8'h20, REG_GES=8'h43, the state enumeration, INIT_LEN and the init table contents.
REQ-034 The init table SHALL be a separate sub-module, paj_init_rom: combinational index in, {reg, data} out.

Verification
REQ-035 Happy path: start with an ACK-always slave model returning 0x20 on reg 0x00 -> write EF/00, WAKE_US wait, read 00, INIT_LEN writes in table order, write EF/00, init_done=1.
REQ-036 Wake NACK: NACK the first command -> no retry; WAKE_WAIT is entered and the sequence completes normally.
REQ-037 Wrong ID: reg 0x00 returns 0x7F -> err=1 with no further cmd_valid; a later start -> WAKE, err=0.
REQ-038 Retry: NACK table entry 2 twice, then ACK -> the same reg/data is issued 3 times and the sequence continues; three NACKs on one command -> ERR.
REQ-039 Poll: reg 0x43 returns 0x00, 0x04, 0x00 -> exactly one gesture_valid pulse with gesture=0x04, and gesture stays 0x04 afterwards.
REQ-040 Abort: assert sys_rstn low while cmd_valid=1 mid-INIT -> all outputs take their REQ-032 values immediately; a stray rsp_valid after reset is ignored.

Source files
------------

// File: rtl/paj_pkg.sv
// paj_pkg: PAJ7620 register constants, sequencer states and the bank-0 bring-up table.
package paj_pkg;
    localparam logic [6:0] PAJ_ADDR = 7'h73;
    localparam logic [7:0] REG_BANK = 8'hEF;
    localparam logic [7:0] REG_ID   = 8'h00;
    localparam logic [7:0] ID_VAL   = 8'h20;
    localparam logic [7:0] REG_GES  = 8'h43;
    localparam int INIT_LEN = 8;
    localparam int IDX_W    = $clog2(INIT_LEN);
    typedef enum logic [3:0] {
        IDLE, WAKE, WAKE_WAIT, CHK_ID, INIT, BANK0, POLL_WAIT, POLL_RD, ERR
    } paj_state_t;
    // {reg, data} pairs written in index order after the ID check
    localparam logic [15:0] INIT_TAB [INIT_LEN] = '{
        16'h3707, 16'h3817, 16'h3906, 16'h4100,
        16'h4200, 16'h462D, 16'h470F, 16'h483C
    };
endpackage

// File: rtl/paj_init_rom.sv
// paj_init_rom: combinational lookup of one bring-up table entry, {reg, data}.
module paj_init_rom
    import paj_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [15:0]      entry
);
    assign entry = INIT_TAB[idx];
endmodule

// File: rtl/paj_cmd_seq.sv
// paj_cmd_seq: PAJ7620 bring-up and gesture-poll sequencer driving a byte-level I2C command master.
module paj_cmd_seq
    import paj_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int WAKE_US   = 1000,
    parameter int POLL_MS   = 100,
    parameter int MAX_RETRY = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic       start,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rd,
    output logic [6:0] cmd_dev,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_data,
    output logic       gesture_valid,
    output logic [7:0] gesture,
    output logic       busy,
    output logic       init_done,
    output logic       err
);
    localparam int          DIV      = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam logic [31:0] DIV_M1   = 32'(DIV - 1);
    localparam logic [31:0] WAKE_M1  = 32'(WAKE_US - 1);
    localparam logic [31:0] POLL_M1  = 32'(POLL_MS * 1000 - 1);
    localparam logic [3:0]  RETRY_M1 = 4'(MAX_RETRY - 1);

    paj_state_t       state;
    logic [31:0]      pre, timer;
    logic [IDX_W-1:0] idx;
    logic [3:0]       retry;
    logic [15:0]      rom_entry;
    logic             pend, tick, is_cmd, ack, nack, nxt_rd;
    logic [7:0]       nxt_reg, nxt_wd;

    paj_init_rom u_rom (.idx(idx), .entry(rom_entry));

    assign cmd_dev = PAJ_ADDR;
    assign tick    = pre == DIV_M1;
    assign ack     = rsp_valid && pend && !rsp_nack;
    assign nack    = rsp_valid && pend && rsp_nack;
    assign is_cmd  = state inside {WAKE, CHK_ID, INIT, BANK0, POLL_RD};

    always_comb begin
        nxt_rd  = state inside {CHK_ID, POLL_RD};
        nxt_reg = state == CHK_ID  ? REG_ID :
                  state == POLL_RD ? REG_GES :
                  state == INIT    ? rom_entry[15:8] : REG_BANK;
        nxt_wd  = state == INIT ? rom_entry[7:0] : 8'h00;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) pre <= '0;
        else pre <= tick ? '0 : pre + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state         <= IDLE;
            cmd_valid     <= 1'b0;
            cmd_rd        <= 1'b0;
            cmd_reg       <= '0;
            cmd_wdata     <= '0;
            pend          <= 1'b0;
            timer         <= '0;
            idx           <= '0;
            retry         <= '0;
            gesture_valid <= 1'b0;
            gesture       <= '0;
            busy          <= 1'b0;
            init_done     <= 1'b0;
            err           <= 1'b0;
        end else begin
            gesture_valid <= 1'b0;
            if (start) begin
                // restart drops any in-flight command; its response is ignored
                state     <= WAKE;
                cmd_valid <= 1'b0;
                pend      <= 1'b0;
                timer     <= '0;
                idx       <= '0;
                retry     <= '0;
                busy      <= 1'b1;
                init_done <= 1'b0;
                err       <= 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    cmd_valid <= 1'b0;
                    pend      <= 1'b1;
                end else if (is_cmd && !cmd_valid && !pend) begin
                    cmd_valid <= 1'b1;
                    cmd_rd    <= nxt_rd;
                    cmd_reg   <= nxt_reg;
                    cmd_wdata <= nxt_wd;
                end
                if (rsp_valid && pend) pend <= 1'b0;
                // a NACK leaves state alone so the same command relaunches next cycle
                if (nack && state != WAKE) begin
                    if (retry == RETRY_M1) begin
                        state     <= ERR;
                        busy      <= 1'b0;
                        init_done <= 1'b0;
                        err       <= 1'b1;
                    end else retry <= retry + 1'b1;
                end
                if (ack) retry <= '0;
                case (state)
                    WAKE: if (rsp_valid && pend) begin
                        state <= WAKE_WAIT;
                        timer <= '0;
                    end
                    WAKE_WAIT: if (tick) begin
                        if (timer == WAKE_M1) state <= CHK_ID;
                        else timer <= timer + 1'b1;
                    end
                    CHK_ID: if (ack) begin
                        if (rsp_data == ID_VAL) state <= INIT;
                        else begin
                            state <= ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                    INIT: if (ack) begin
                        if (idx == IDX_W'(INIT_LEN - 1)) state <= BANK0;
                        else idx <= idx + 1'b1;
                    end
                    BANK0: if (ack) begin
                        state     <= POLL_WAIT;
                        timer     <= '0;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end
                    POLL_WAIT: if (tick) begin
                        if (timer == POLL_M1) begin
                            state <= POLL_RD;
                            busy  <= 1'b1;
                        end else timer <= timer + 1'b1;
                    end
                    POLL_RD: if (ack) begin
                        state <= POLL_WAIT;
                        timer <= '0;
                        busy  <= 1'b0;
                        if (rsp_data != 8'h00) begin
                            gesture       <= rsp_data;
                            gesture_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_paj_cmd_seq.sv
// tb_paj_cmd_seq: randomized-latency I2C slave model plus scenario tasks checking the PAJ7620 sequencer.
module tb_paj_cmd_seq;
    localparam int PER = 10;
    localparam int DIVT = 4;
    localparam int WUS = 5;
    localparam int MR = 3;
    localparam logic [15:0] TAB [8] = '{16'h3707, 16'h3817, 16'h3906, 16'h4100,
                                        16'h4200, 16'h462D, 16'h470F, 16'h483C};

    logic       sys_clk = 1'b0, sys_rstn, start;
    logic       cmd_valid, cmd_ready, cmd_rd, rsp_valid, rsp_nack;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg, cmd_wdata, rsp_data, gesture;
    logic       gesture_valid, busy, init_done, err;

    int total = 0, bad = 0;
    logic [16:0] log_q[$], exp_q[$];
    time t_seen[$], t_rsp[$];
    logic        slave_en = 1'b1, ges_on = 1'b0, rsp_is_ges = 1'b0;
    logic [7:0]  id_val = 8'h20;
    logic [16:0] nk_cmd = '0;
    int nk_n = 0, nk_base = 0, nk_done = 0;
    int ges_rd = 0, ges_base = 0, unstable = 0, stray_req = 0, stray_done = 0;
    logic [7:0] ges_vals [3];
    int cv_cnt = 0, gv_cnt = 0, gv_bad = 0;

    paj_cmd_seq #(.CLK_HZ(4_000_000), .WAKE_US(WUS), .POLL_MS(1), .MAX_RETRY(MR)) dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_dev(cmd_dev),
        .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .rsp_data(rsp_data), .gesture_valid(gesture_valid), .gesture(gesture),
        .busy(busy), .init_done(init_done), .err(err)
    );

    always #(PER / 2) sys_clk = ~sys_clk;

    // slave: random ready and response latency, scripted NACKs and read data
    initial begin : slave
        logic [16:0] c;
        logic nk;
        logic [7:0] d;
        int k;
        cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_data = 0;
        forever begin
            @(negedge sys_clk);
            if (stray_req != stray_done) begin
                rsp_valid = 1; rsp_nack = 0; rsp_data = 8'h20;
                @(negedge sys_clk);
                rsp_valid = 0;
                stray_done++;
            end else if (slave_en && cmd_valid) begin
                c = {cmd_rd, cmd_reg, cmd_wdata};
                t_seen.push_back($time);
                repeat ($urandom_range(0, 2)) begin
                    @(negedge sys_clk);
                    if (cmd_valid !== 1'b1 || {cmd_rd, cmd_reg, cmd_wdata} !== c) unstable++;
                end
                cmd_ready = 1;
                log_q.push_back(c);
                @(negedge sys_clk);
                cmd_ready = 0;
                if (cmd_valid !== 1'b0) unstable++;
                nk = (c == nk_cmd) && (nk_done - nk_base < nk_n);
                if (nk) nk_done++;
                d = 8'($urandom);
                if (c[16] && c[15:8] == 8'h00) d = id_val;
                if (c[16] && c[15:8] == 8'h43) begin
                    k = ges_rd - ges_base;
                    d = (ges_on && k < 3) ? ges_vals[k] : 8'h00;
                    ges_rd++;
                end
                repeat ($urandom_range(0, 3)) begin
                    @(negedge sys_clk);
                    if (cmd_valid !== 1'b0) unstable++;
                end
                rsp_valid = 1; rsp_nack = nk; rsp_data = d; rsp_is_ges = c[16] && c[15:8] == 8'h43;
                t_rsp.push_back($time);
                @(negedge sys_clk);
                rsp_valid = 0; rsp_nack = 0; rsp_is_ges = 0;
            end
        end
    end

    // gesture_valid must follow exactly the edge that saw a nonzero poll response
    always @(posedge sys_clk) begin
        #1;
        if (cmd_valid === 1'b1) cv_cnt++;
        if (gesture_valid === 1'b1) gv_cnt++;
        if (gesture_valid !== (rsp_valid && rsp_is_ges && rsp_data != 8'h00)) gv_bad++;
        if (gesture_valid === 1'b1 && gesture !== rsp_data) gv_bad++;
    end

    function automatic void build_exp(input logic [7:0] id, input int k, input int n);
        int nn;
        exp_q = {};
        exp_q.push_back({1'b0, 16'hEF00});
        exp_q.push_back({1'b1, 16'h0000});
        if (id != 8'h20) return;
        for (int i = 0; i < 8; i++) begin
            nn = (i == k) ? n : 0;
            for (int j = 0; j < ((nn >= MR) ? MR : nn + 1); j++) exp_q.push_back({1'b0, TAB[i]});
            if (nn >= MR) return;
        end
        exp_q.push_back({1'b0, 16'hEF00});
    endfunction

    task automatic pulse_start();
        for (int i = 0; i < 20000 && busy !== 1'b0; i++) @(negedge sys_clk);
        start = 1;
        @(negedge sys_clk);
        start = 0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
        total++; if (cmd_rd !== 1'b0) begin bad++; $display("FAIL rst_cmd_rd: got %b want 0", cmd_rd); end
        total++; if (cmd_reg !== 8'h00 || cmd_wdata !== 8'h00) begin bad++; $display("FAIL rst_cmd_bytes: got %h/%h want 00/00", cmd_reg, cmd_wdata); end
        total++; if (cmd_dev !== 7'h73) begin bad++; $display("FAIL rst_cmd_dev: got %h want 73", cmd_dev); end
        total++; if (gesture !== 8'h00 || gesture_valid !== 1'b0) begin bad++; $display("FAIL rst_gesture: got %h/%b want 00/0", gesture, gesture_valid); end
        total++; if ({busy, init_done, err} !== 3'b000) begin bad++; $display("FAIL rst_status: got %b want 000", {busy, init_done, err}); end
        sys_rstn = 1;
        repeat (5) @(negedge sys_clk);
        total++; if (cv_cnt !== 0 || busy !== 1'b0) begin bad++; $display("FAIL idle_quiet: got cv=%0d busy=%b want 0/0", cv_cnt, busy); end
    endtask

    task automatic test_happy();
        int base, nb, g;
        base = log_q.size();
        build_exp(8'h20, -1, 0);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL happy_busy: got %b want 1", busy); end
        for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge sys_clk);
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL happy_init_done: got %b want 1", init_done); end
        nb = 0;
        for (int i = 0; i < exp_q.size(); i++) if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) nb++;
        total++; if (nb != 0 || log_q.size() != base + exp_q.size()) begin bad++; $display("FAIL happy_cmds: %0d wrong, got %0d cmds want %0d", nb, log_q.size() - base, exp_q.size()); end
        g = (t_seen.size() > base + 1 && t_rsp.size() > base) ? int'((t_seen[base + 1] - t_rsp[base]) / PER) : -1;
        total++; if (g < (WUS - 1) * DIVT + 3 || g > WUS * DIVT + 2) begin bad++; $display("FAIL happy_wake_gap: got %0d cycles want %0d..%0d", g, (WUS - 1) * DIVT + 3, WUS * DIVT + 2); end
        total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL happy_poll_wait: got busy=%b err=%b want 0/0", busy, err); end
        total++; if (unstable != 0) begin bad++; $display("FAIL happy_handshake: got %0d violations want 0", unstable); end
    endtask

    task automatic test_poll();
        int gv0, gb0, np;
        logic [7:0] eg;
        ges_vals = '{8'h00, 8'h04, 8'h00};
        np = 0; eg = gesture;
        for (int i = 0; i < 3; i++) if (ges_vals[i] != 8'h00) begin np++; eg = ges_vals[i]; end
        gv0 = gv_cnt; gb0 = gv_bad;
        ges_base = ges_rd; ges_on = 1;
        for (int i = 0; i < 14000 && ges_rd - ges_base < 3; i++) @(negedge sys_clk);
        repeat (10) @(negedge sys_clk);
        ges_on = 0;
        total++; if (ges_rd - ges_base < 3) begin bad++; $display("FAIL poll_reads: got %0d want 3", ges_rd - ges_base); end
        total++; if (gv_cnt - gv0 != np) begin bad++; $display("FAIL poll_pulses: got %0d want %0d", gv_cnt - gv0, np); end
        total++; if (gesture !== eg) begin bad++; $display("FAIL poll_gesture: got %h want %h", gesture, eg); end
        total++; if (gv_bad != gb0) begin bad++; $display("FAIL poll_pulse_timing: got %0d bad cycles want 0", gv_bad - gb0); end
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL poll_init_done: got %b want 1", init_done); end
    endtask

    task automatic test_wake_nack();
        int base, nb;
        nk_base = nk_done; nk_cmd = {1'b0, 16'hEF00}; nk_n = 1;
        base = log_q.size();
        build_exp(8'h20, -1, 0);
        pulse_start();
        for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge sys_clk);
        nb = 0;
        for (int i = 0; i < exp_q.size(); i++) if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) nb++;
        total++; if (nb != 0 || log_q.size() != base + exp_q.size()) begin bad++; $display("FAIL wake_nack_cmds: %0d wrong, got %0d cmds want %0d", nb, log_q.size() - base, exp_q.size()); end
        total++; if (nk_done - nk_base != 1 || init_done !== 1'b1) begin bad++; $display("FAIL wake_nack_done: got nacks=%0d init_done=%b want 1/1", nk_done - nk_base, init_done); end
        nk_n = 0;
    endtask

    task automatic test_wrong_id();
        int base, cv0;
        logic [7:0] ids [2];
        ids[0] = 8'h7F;
        ids[1] = 8'($urandom_range(0, 255));
        if (ids[1] == 8'h20) ids[1] = 8'h21;
        for (int r = 0; r < 2; r++) begin
            id_val = ids[r];
            base = log_q.size();
            pulse_start();
            for (int i = 0; i < 2000 && err !== 1'b1; i++) @(negedge sys_clk);
            total++; if ({err, busy, init_done} !== 3'b100) begin bad++; $display("FAIL wrong_id_%0h_status: got err/busy/init=%b want 100", ids[r], {err, busy, init_done}); end
            cv0 = cv_cnt;
            repeat (60) @(negedge sys_clk);
            total++; if (cv_cnt != cv0 || log_q.size() != base + 2) begin bad++; $display("FAIL wrong_id_%0h_quiet: got %0d cv cycles, %0d cmds want 0/2", ids[r], cv_cnt - cv0, log_q.size() - base); end
        end
        base = log_q.size();
        pulse_start();
        id_val = 8'h20;
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wrong_id_restart: got err=%b busy=%b want 0/1", err, busy); end
        for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge sys_clk);
        total++; if (init_done !== 1'b1 || log_q.size() <= base || log_q[base] !== {1'b0, 16'hEF00}) begin bad++; $display("FAIL wrong_id_recover: got init_done=%b first=%h want 1/0ef00", init_done, (log_q.size() > base) ? log_q[base] : 17'h0); end
    endtask

    task automatic test_retry();
        int base, nb;
        for (int n = 2; n <= 3; n++) begin
            nk_base = nk_done; nk_cmd = {1'b0, TAB[2]}; nk_n = n;
            base = log_q.size();
            build_exp(8'h20, 2, n);
            pulse_start();
            for (int i = 0; i < 2000 && init_done !== 1'b1 && err !== 1'b1; i++) @(negedge sys_clk);
            repeat (20) @(negedge sys_clk);
            nb = 0;
            for (int i = 0; i < exp_q.size(); i++) if (base + i >= log_q.size() || log_q[base + i] !== exp_q[i]) nb++;
            total++; if (nb != 0 || log_q.size() != base + exp_q.size()) begin bad++; $display("FAIL retry%0d_cmds: %0d wrong, got %0d cmds want %0d", n, nb, log_q.size() - base, exp_q.size()); end
            total++; if ({init_done, err} !== ((n < MR) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL retry%0d_status: got init/err=%b want %b", n, {init_done, err}, (n < MR) ? 2'b10 : 2'b01); end
        end
        nk_n = 0;
    endtask

    task automatic test_abort();
        int base, cv0;
        base = log_q.size();
        pulse_start();
        for (int i = 0; i < 2000 && log_q.size() < base + 4; i++) @(negedge sys_clk);
        slave_en = 0;
        repeat (2) @(negedge sys_clk);
        for (int i = 0; i < 50 && cmd_valid !== 1'b1; i++) @(negedge sys_clk);
        total++; if (cmd_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL abort_setup: got cmd_valid=%b busy=%b want 1/1", cmd_valid, busy); end
        #2 sys_rstn = 0;
        #1;
        total++; if ({cmd_valid, cmd_rd, busy, init_done, err, gesture_valid} !== 6'b0) begin bad++; $display("FAIL abort_flags: got %b want 000000", {cmd_valid, cmd_rd, busy, init_done, err, gesture_valid}); end
        total++; if (cmd_reg !== 8'h00 || cmd_wdata !== 8'h00 || gesture !== 8'h00) begin bad++; $display("FAIL abort_bytes: got %h/%h/%h want 00/00/00", cmd_reg, cmd_wdata, gesture); end
        repeat (2) @(negedge sys_clk);
        sys_rstn = 1;
        cv0 = cv_cnt;
        stray_req++;
        repeat (20) @(negedge sys_clk);
        total++; if (cv_cnt != cv0 || {busy, init_done, err} !== 3'b000) begin bad++; $display("FAIL abort_stray: got cv=%0d status=%b want 0/000", cv_cnt - cv0, {busy, init_done, err}); end
    endtask

    initial begin
        sys_rstn = 0;
        start = 0;
        test_reset();
        test_happy();
        test_poll();
        test_wake_nack();
        test_wrong_id();
        test_retry();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
